// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the RV32I decode stage.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instruction;
    logic            o_valid;
    logic            i_ready;
    logic [6:0]      o_opcode;
    logic [4:0]      o_rd;
    logic [2:0]      o_funct3;
    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic [6:0]      o_funct7;
    logic [XLEN-1:0] o_immediate;
    logic [2:0]      o_fmt;
    logic            o_illegal;

    modport master (
        output i_flush, i_valid, i_instruction, i_ready,
        input  o_ready, o_valid, o_opcode, o_rd, o_funct3, o_rs1, o_rs2,
               o_funct7, o_immediate, o_fmt, o_illegal
    );

    modport slave (
        input  i_flush, i_valid, i_instruction, i_ready,
        output o_ready, o_valid, o_opcode, o_rd, o_funct3, o_rs1, o_rs2,
               o_funct7, o_immediate, o_fmt, o_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes on entry, holds results in an output
// register plus one skid entry so the upstream ready is a flop.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit CHECK_ILL = 1'b1
) (
    input logic          i_clk,
    input logic          i_rst,
    decode_stage_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // Opcodes not listed here (including every word whose low two bits are
    // not 2'b11) fall into the default arm and are flagged illegal.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t        d;
        logic [31:0] imm32;
        logic        ill;
        fmt_e        fmt;
        logic [6:0]  f7;
        logic [2:0]  f3;
        f7       = ins[31:25];
        f3       = ins[14:12];
        d.opcode = ins[6:0];
        d.rd     = ins[11:7];
        d.funct3 = f3;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct7 = f7;
        imm32    = '0;
        ill      = 1'b0;
        fmt      = FMT_R;
        case (ins[6:0])
            7'h33: begin
                fmt = FMT_R;
                if (f7 == 7'h20)
                    ill = !(f3 == 3'b000 || f3 == 3'b101);
                else
                    ill = (f7 != 7'h00);
            end
            7'h13: begin
                fmt   = FMT_I;
                imm32 = {{20{ins[31]}}, ins[31:20]};
                if (f3 == 3'b001)
                    ill = (f7 != 7'h00);
                else if (f3 == 3'b101)
                    ill = !(f7 == 7'h00 || f7 == 7'h20);
            end
            7'h03, 7'h67, 7'h73, 7'h0F: begin
                fmt   = FMT_I;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'h23: begin
                fmt   = FMT_S;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'h63: begin
                fmt   = FMT_B;
                imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                fmt   = FMT_U;
                imm32 = {ins[31:12], 12'b0};
            end
            7'h6F: begin
                fmt   = FMT_J;
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: ill = 1'b1;
        endcase
        if (!CHECK_ILL) begin
            ill = 1'b0;
        end else if (ill) begin
            fmt   = FMT_ILL;
            imm32 = '0;
        end
        d.imm     = sext(imm32);
        d.fmt     = fmt;
        d.illegal = ill;
        return d;
    endfunction

    dec_t or_q, or_d;
    dec_t sk_q, sk_d;
    logic or_vld_q, or_vld_d;
    logic sk_vld_q, sk_vld_d;
    logic rdy_q, rdy_d;
    dec_t dec_in;
    logic accept;
    logic or_free;

    always_comb begin
        dec_in   = decode(bus.i_instruction);
        accept   = bus.i_valid & rdy_q;
        or_free  = ~or_vld_q | bus.i_ready;
        or_d     = or_q;
        sk_d     = sk_q;
        or_vld_d = or_vld_q;
        sk_vld_d = sk_vld_q;
        if (bus.i_flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (or_free) begin
            if (sk_vld_q) begin
                or_d     = sk_q;
                or_vld_d = 1'b1;
                sk_vld_d = accept;
                if (accept)
                    sk_d = dec_in;
            end else begin
                or_vld_d = accept;
                if (accept)
                    or_d = dec_in;
            end
        end else if (accept) begin
            sk_d     = dec_in;
            sk_vld_d = 1'b1;
        end
        // Ready depends only on next skid occupancy, never on i_ready directly.
        rdy_d = ~sk_vld_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            or_q     <= '0;
            sk_q     <= '0;
            or_vld_q <= 1'b0;
            sk_vld_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            or_q     <= or_d;
            sk_q     <= sk_d;
            or_vld_q <= or_vld_d;
            sk_vld_q <= sk_vld_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.o_ready     = rdy_q;
    assign bus.o_valid     = or_vld_q;
    assign bus.o_opcode    = or_q.opcode;
    assign bus.o_rd        = or_q.rd;
    assign bus.o_funct3    = or_q.funct3;
    assign bus.o_rs1       = or_q.rs1;
    assign bus.o_rs2       = or_q.rs2;
    assign bus.o_funct7    = or_q.funct7;
    assign bus.o_immediate = or_q.imm;
    assign bus.o_fmt       = or_q.fmt;
    assign bus.o_illegal   = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I words with hand-decoded fields.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [31:0] vin[12];
    exp_t        vexp[12];

    decode_stage_if #(.XLEN(32)) bus();

    decode_stage #(.XLEN(32), .CHECK_ILL(1'b1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] opc, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [2:0] fmt,
                                input logic ill);
        exp_t e;
        e = '{opc, rd, f3, rs1, rs2, f7, imm, fmt, ill};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_accept(input exp_t e, input bit track);
        bit done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (bus.o_ready) begin
                if (track) sb.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 expected acceptance within 50 cycles");
        end
    endtask

    task automatic send(input logic [31:0] ins, input exp_t e, input bit track);
        bus.i_instruction = ins;
        bus.i_valid       = 1'b1;
        wait_accept(e, track);
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (!rst && !bus.i_flush && bus.o_valid && bus.i_ready) begin
            act = '{bus.o_opcode, bus.o_rd, bus.o_funct3, bus.o_rs1, bus.o_rs2,
                    bus.o_funct7, bus.o_immediate, bus.o_fmt, bus.o_illegal};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected no transfer", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL decode_out: got %h expected %h", act, e);
                end
            end
        end
    end

    initial begin
        vin[0]  = 32'h00F00513; vexp[0]  = mk(7'h13, 5'd10, 3'd0, 5'd0, 5'd15, 7'h00, 32'h0000000F, 3'd1, 1'b0);
        vin[1]  = 32'hFFF00793; vexp[1]  = mk(7'h13, 5'd15, 3'd0, 5'd0, 5'd31, 7'h7F, 32'hFFFFFFFF, 3'd1, 1'b0);
        vin[2]  = 32'h00512423; vexp[2]  = mk(7'h23, 5'd8,  3'd2, 5'd2, 5'd5,  7'h00, 32'h00000008, 3'd2, 1'b0);
        vin[3]  = 32'hFE000EE3; vexp[3]  = mk(7'h63, 5'd29, 3'd0, 5'd0, 5'd0,  7'h7F, 32'hFFFFFFFC, 3'd3, 1'b0);
        vin[4]  = 32'h123452B7; vexp[4]  = mk(7'h37, 5'd5,  3'd5, 5'd8, 5'd3,  7'h09, 32'h12345000, 3'd4, 1'b0);
        vin[5]  = 32'h00000000; vexp[5]  = mk(7'h00, 5'd0,  3'd0, 5'd0, 5'd0,  7'h00, 32'h00000000, 3'd7, 1'b1);
        vin[6]  = 32'h40001033; vexp[6]  = mk(7'h33, 5'd0,  3'd1, 5'd0, 5'd0,  7'h20, 32'h00000000, 3'd7, 1'b1);
        vin[7]  = 32'h008000EF; vexp[7]  = mk(7'h6F, 5'd1,  3'd0, 5'd0, 5'd8,  7'h00, 32'h00000008, 3'd5, 1'b0);
        vin[8]  = 32'h002081B3; vexp[8]  = mk(7'h33, 5'd3,  3'd0, 5'd1, 5'd2,  7'h00, 32'h00000000, 3'd0, 1'b0);
        vin[9]  = 32'h402081B3; vexp[9]  = mk(7'h33, 5'd3,  3'd0, 5'd1, 5'd2,  7'h20, 32'h00000000, 3'd0, 1'b0);
        vin[10] = 32'h40009093; vexp[10] = mk(7'h13, 5'd1,  3'd1, 5'd1, 5'd0,  7'h20, 32'h00000000, 3'd7, 1'b1);
        vin[11] = 32'h00F00511; vexp[11] = mk(7'h11, 5'd10, 3'd0, 5'd0, 5'd15, 7'h00, 32'h00000000, 3'd7, 1'b1);

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_instruction = '0;
        bus.i_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid",  64'(bus.o_valid), 64'd0);
        chk("rst_ready",  64'(bus.o_ready), 64'd0);
        chk("rst_opcode", 64'(bus.o_opcode), 64'd0);
        chk("rst_imm",    64'(bus.o_immediate), 64'd0);
        chk("rst_fmt",    64'(bus.o_fmt), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(bus.o_ready), 64'd1);

        // Single transfer, then a back-to-back stream with downstream always ready.
        bus.i_ready = 1'b1;
        send(vin[0], vexp[0], 1'b1);
        bus.i_valid = 1'b0;
        chk("latency_valid", 64'(bus.o_valid), 64'd1);
        tick();
        for (int i = 1; i < 12; i++) send(vin[i], vexp[i], 1'b1);
        bus.i_valid = 1'b0;
        repeat (3) tick();
        chk("stream_drained", 64'(sb.size()), 64'd0);

        // Backpressure: A held, B in skid, C stalls until downstream opens.
        bus.i_ready = 1'b0;
        send(vin[2], vexp[2], 1'b1);
        send(vin[3], vexp[3], 1'b1);
        chk("skid_valid",  64'(bus.o_valid), 64'd1);
        chk("skid_opcode", 64'(bus.o_opcode), 64'h23);
        chk("skid_ready",  64'(bus.o_ready), 64'd0);
        bus.i_instruction = vin[4];
        bus.i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rd",    64'(bus.o_rd), 64'd8);
            chk("hold_imm",   64'(bus.o_immediate), 64'h8);
            chk("hold_ready", 64'(bus.o_ready), 64'd0);
        end
        bus.i_ready = 1'b1;
        wait_accept(vexp[4], 1'b1);
        bus.i_valid = 1'b0;
        repeat (4) tick();
        chk("skid_drained", 64'(sb.size()), 64'd0);

        // Flush with skid full and an input presented.
        bus.i_ready = 1'b0;
        send(vin[0], vexp[0], 1'b0);
        send(vin[1], vexp[1], 1'b0);
        bus.i_instruction = vin[4];
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush_valid", 64'(bus.o_valid), 64'd0);
        chk("flush_ready", 64'(bus.o_ready), 64'd1);
        bus.i_ready = 1'b1;
        repeat (3) tick();

        // Flush drops an input accepted in the same cycle.
        bus.i_ready = 1'b0;
        send(vin[7], vexp[7], 1'b0);
        bus.i_instruction = vin[8];
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush_acc_valid", 64'(bus.o_valid), 64'd0);
        chk("flush_acc_ready", 64'(bus.o_ready), 64'd1);
        bus.i_ready = 1'b1;
        repeat (3) tick();

        // Reset mid-stream with skid full.
        bus.i_ready = 1'b0;
        send(vin[7], vexp[7], 1'b0);
        send(vin[8], vexp[8], 1'b0);
        rst = 1'b1;
        tick();
        chk("mrst_valid",  64'(bus.o_valid), 64'd0);
        chk("mrst_ready",  64'(bus.o_ready), 64'd0);
        chk("mrst_opcode", 64'(bus.o_opcode), 64'd0);
        rst = 1'b0;
        bus.i_valid = 1'b0;
        tick();
        chk("mrst_ready_after", 64'(bus.o_ready), 64'd1);
        chk("mrst_valid_after", 64'(bus.o_valid), 64'd0);
        bus.i_ready = 1'b1;
        repeat (3) tick();

        send(vin[9], vexp[9], 1'b1);
        bus.i_valid = 1'b0;
        repeat (3) tick();
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
